// File: rtl/seg7_scan_mux_if.sv
// seg7_scan_mux_if: connection bundle between a digit source and the
// 7-segment scan multiplexer.
//   enable      : scanning enable (source -> mux)
//   digits_in   : packed segment patterns, digit k at [8k+7:8k] (source -> mux)
//   seg         : shared segment bus, physical polarity (mux -> display)
//   dig_en      : one-hot digit enable, physical polarity (mux -> display)
//   frame_start : one-cycle pulse at the start of digit 0's slot (mux -> source)
interface seg7_scan_mux_if #(
  parameter int NUM_DIGITS = 3
);
  logic                    enable;
  logic [8*NUM_DIGITS-1:0] digits_in;
  logic [7:0]              seg;
  logic [NUM_DIGITS-1:0]   dig_en;
  logic                    frame_start;

  modport master (
    output enable,
    output digits_in,
    input  seg,
    input  dig_en,
    input  frame_start
  );

  modport slave (
    input  enable,
    input  digits_in,
    output seg,
    output dig_en,
    output frame_start
  );
endinterface

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: time-multiplexes NUM_DIGITS segment patterns onto one
// shared segment bus with per-digit enables. Every slot of CLK_DIV cycles
// begins with BLANK_CYCLES of darkness to avoid ghosting; all digits are
// snapshotted at frame start so a rippling counter upstream cannot tear.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (outputs go dark immediately)
//   bus   : seg7_scan_mux_if.slave (enable, digits_in in; seg, dig_en,
//           frame_start out, all outputs registered)
module seg7_scan_mux #(
  parameter int NUM_DIGITS     = 3,
  parameter int CLK_DIV        = 1000,
  parameter int BLANK_CYCLES   = 50,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  seg7_scan_mux_if.slave   bus
);

  localparam int CNT_W  = $clog2(CLK_DIV);
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SNAP_W = 8 * NUM_DIGITS;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

  // Inactive levels after polarity; XOR with these applies the polarity.
  localparam logic [7:0] SEG_OFF =
    (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF =
    (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic [NUM_DIGITS-1:0] DIG_ONE = NUM_DIGITS'(1);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [SNAP_W-1:0]     snap_q, snap_d;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_q, dig_d;
  logic                  fs_q, fs_d;

  logic                  frame_start_s;
  logic                  blank_s;
  logic [7:0]            show_seg_s;

  // With no blanking the compare would be against zero, so drop it entirely.
  if (BLANK_CYCLES > 0) begin : g_blank
    assign blank_s = (cnt_q < CNT_W'(BLANK_CYCLES));
  end else begin : g_noblank
    assign blank_s = 1'b0;
  end

  assign frame_start_s = bus.enable && (cnt_q == '0) && (idx_q == '0);

  // Use the freshly captured pattern on the frame-start cycle itself, so a
  // zero-blank digit 0 already shows this frame's data.
  assign show_seg_s = snap_d[{idx_q, 3'b000} +: 8];

  // Slot counter, digit index, snapshot and output next-state.
  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    snap_d = snap_q;
    seg_d  = SEG_OFF;
    dig_d  = DIG_OFF;
    fs_d   = 1'b0;
    if (!bus.enable) begin
      cnt_d = '0;
      idx_d = '0;
    end else begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = '0;
        if (idx_q == IDX_MAX) begin
          idx_d = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (frame_start_s) begin
        snap_d = bus.digits_in;
      end else begin
        snap_d = snap_q;
      end
      fs_d = frame_start_s;
      if (blank_s) begin
        seg_d = SEG_OFF;
        dig_d = DIG_OFF;
      end else begin
        seg_d = show_seg_s ^ SEG_OFF;
        dig_d = (DIG_ONE << idx_q) ^ DIG_OFF;
      end
    end
  end

  // State and registered outputs; reset drives the display dark at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      snap_q <= '0;
      seg_q  <= SEG_OFF;
      dig_q  <= DIG_OFF;
      fs_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      snap_q <= snap_d;
      seg_q  <= seg_d;
      dig_q  <= dig_d;
      fs_q   <= fs_d;
    end
  end

  assign bus.seg         = seg_q;
  assign bus.dig_en      = dig_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb_seg7_scan_mux: three scan multiplexers (normal, inverted polarity,
// zero blanking) driven with identical stimulus. Directed steps check the
// documented cycle positions; a frame-position reference model checks every
// output of every instance on every cycle, including during random stimulus.
module tb_seg7_scan_mux;

  localparam int N  = 3;
  localparam int CD = 8;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_s  = 1'b0;
  logic [23:0] dig_s = 24'h0;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: position within the frame, 0 .. N*CD-1.
  int          pos   [3];
  logic [23:0] snap  [3];
  logic [7:0]  e_seg [3];
  logic [2:0]  e_dig [3];
  logic        e_fs  [3];
  int          blank_p [3] = '{2, 2, 0};
  bit          inv_p   [3] = '{1'b0, 1'b1, 1'b0};

  seg7_scan_mux_if #(.NUM_DIGITS(N)) bus0 ();
  seg7_scan_mux_if #(.NUM_DIGITS(N)) bus1 ();
  seg7_scan_mux_if #(.NUM_DIGITS(N)) bus2 ();

  assign bus0.enable    = en_s;
  assign bus1.enable    = en_s;
  assign bus2.enable    = en_s;
  assign bus0.digits_in = dig_s;
  assign bus1.digits_in = dig_s;
  assign bus2.digits_in = dig_s;

  seg7_scan_mux #(.NUM_DIGITS(N), .CLK_DIV(CD), .BLANK_CYCLES(2),
                  .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0))
    u_norm (.clk(clk), .rst_n(rst_n), .bus(bus0));
  seg7_scan_mux #(.NUM_DIGITS(N), .CLK_DIV(CD), .BLANK_CYCLES(2),
                  .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1))
    u_inv  (.clk(clk), .rst_n(rst_n), .bus(bus1));
  seg7_scan_mux #(.NUM_DIGITS(N), .CLK_DIV(CD), .BLANK_CYCLES(0),
                  .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0))
    u_nobl (.clk(clk), .rst_n(rst_n), .bus(bus2));

  always #5 clk = ~clk;

  function automatic logic [7:0] obs_seg(input int i);
    case (i)
      0:       return bus0.seg;
      1:       return bus1.seg;
      default: return bus2.seg;
    endcase
  endfunction

  function automatic logic [2:0] obs_dig(input int i);
    case (i)
      0:       return bus0.dig_en;
      1:       return bus1.dig_en;
      default: return bus2.dig_en;
    endcase
  endfunction

  function automatic logic obs_fs(input int i);
    case (i)
      0:       return bus0.frame_start;
      1:       return bus1.frame_start;
      default: return bus2.frame_start;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      pos[i]   = 0;
      e_seg[i] = inv_p[i] ? 8'hFF : 8'h00;
      e_dig[i] = inv_p[i] ? 3'b111 : 3'b000;
      e_fs[i]  = 1'b0;
    end
  endtask

  // Advance the model by one clock edge using the inputs the DUT samples.
  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      logic [7:0] ls;
      logic [2:0] ld;
      int d, off;
      ls = 8'h00;
      ld = 3'b000;
      if (!rst_n || !en_s) begin
        pos[i]  = 0;
        e_fs[i] = 1'b0;
      end else begin
        e_fs[i] = (pos[i] == 0);
        if (pos[i] == 0) snap[i] = dig_s;
        d   = pos[i] / CD;
        off = pos[i] % CD;
        if (off >= blank_p[i]) begin
          ls = snap[i][8*d +: 8];
          ld = 3'(1 << d);
        end
        pos[i] = (pos[i] + 1) % (N * CD);
      end
      e_seg[i] = ls ^ {8{inv_p[i]}};
      e_dig[i] = ld ^ {3{inv_p[i]}};
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      logic [7:0] ls;
      logic [2:0] ld;
      chk($sformatf("seg[%0d] c%0d", i, cyc), obs_seg(i), e_seg[i]);
      chk($sformatf("dig[%0d] c%0d", i, cyc), obs_dig(i), e_dig[i]);
      chk($sformatf("fs[%0d] c%0d", i, cyc), obs_fs(i), e_fs[i]);
      ls = obs_seg(i) ^ {8{inv_p[i]}};
      ld = obs_dig(i) ^ {3{inv_p[i]}};
      chk($sformatf("onehot[%0d] c%0d", i, cyc), ($countones(ld) <= 1), 1);
      chk($sformatf("dark[%0d] c%0d", i, cyc), ((ld != 3'b000) || (ls == 8'h00)), 1);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    check_all();
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  initial begin
    en_s  = 1'b1;
    dig_s = 24'h5B063F;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset seg", bus0.seg, 8'h00);
    chk("reset dig", bus0.dig_en, 3'b000);
    chk("reset fs", bus0.frame_start, 1'b0);
    chk("reset inv seg", bus1.seg, 8'hFF);
    chk("reset inv dig", bus1.dig_en, 3'b111);

    // Scenario: reset release, full frame, mid-frame digit change.
    rst_n = 1'b1;
    cyc   = 0;
    run_to(1);
    chk("c1 fs", bus0.frame_start, 1'b1);
    chk("c1 dig", bus0.dig_en, 3'b000);
    chk("c1 inv seg", bus1.seg, 8'hFF);
    chk("c1 inv dig", bus1.dig_en, 3'b111);
    chk("c1 nobl dig", bus2.dig_en, 3'b001);
    run_to(2);
    chk("c2 dig", bus0.dig_en, 3'b000);
    chk("c2 fs", bus0.frame_start, 1'b0);
    run_to(3);
    chk("c3 dig", bus0.dig_en, 3'b001);
    chk("c3 seg", bus0.seg, 8'h3F);
    chk("c3 inv seg", bus1.seg, 8'hC0);
    chk("c3 inv dig", bus1.dig_en, 3'b110);
    run_to(5);
    dig_s = 24'h7F7F7F;
    run_to(8);
    chk("c8 dig", bus0.dig_en, 3'b001);
    chk("c8 nobl dig", bus2.dig_en, 3'b001);
    run_to(9);
    chk("c9 dig", bus0.dig_en, 3'b000);
    chk("c9 nobl dig", bus2.dig_en, 3'b010);
    run_to(11);
    chk("c11 dig", bus0.dig_en, 3'b010);
    chk("c11 seg", bus0.seg, 8'h06);
    run_to(17);
    chk("c17 nobl dig", bus2.dig_en, 3'b100);
    run_to(19);
    chk("c19 dig", bus0.dig_en, 3'b100);
    chk("c19 seg", bus0.seg, 8'h5B);
    run_to(24);
    chk("c24 fs", bus0.frame_start, 1'b0);
    run_to(25);
    chk("c25 fs", bus0.frame_start, 1'b1);
    run_to(27);
    chk("c27 seg", bus0.seg, 8'h7F);
    chk("c27 dig", bus0.dig_en, 3'b001);

    // Scenario: asynchronous reset during a SHOW phase.
    run_to(30);
    chk("c30 pre-reset dig", bus0.dig_en, 3'b001);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async seg", bus0.seg, 8'h00);
    chk("async dig", bus0.dig_en, 3'b000);
    chk("async inv seg", bus1.seg, 8'hFF);
    chk("async inv dig", bus1.dig_en, 3'b111);
    step();
    step();
    dig_s = 24'h5B063F;
    rst_n = 1'b1;
    cyc   = 0;

    // Scenario: restart matches first frame, then enable dropped at cycle 13.
    run_to(1);
    chk("r c1 fs", bus0.frame_start, 1'b1);
    run_to(3);
    chk("r c3 seg", bus0.seg, 8'h3F);
    run_to(11);
    chk("r c11 seg", bus0.seg, 8'h06);
    run_to(13);
    en_s = 1'b0;
    run_to(14);
    chk("en c14 dig", bus0.dig_en, 3'b000);
    chk("en c14 seg", bus0.seg, 8'h00);
    run_to(18);
    en_s = 1'b1;
    run_to(19);
    chk("en c19 fs", bus0.frame_start, 1'b1);
    run_to(20);
    chk("en c20 dig", bus0.dig_en, 3'b000);
    run_to(21);
    chk("en c21 dig", bus0.dig_en, 3'b001);
    chk("en c21 seg", bus0.seg, 8'h3F);

    // Random stimulus against the model, with one asynchronous reset.
    for (int it = 0; it < 600; it++) begin
      if ($urandom_range(9, 0) == 0) dig_s = 24'($urandom);
      if (en_s) begin
        if ($urandom_range(29, 0) == 0) en_s = 1'b0;
      end else begin
        if ($urandom_range(3, 0) == 0) en_s = 1'b1;
      end
      if (it == 300) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rand async seg", bus0.seg, 8'h00);
        chk("rand async dig", bus1.dig_en, 3'b111);
        step();
        step();
        rst_n = 1'b1;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
